// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Modulo-n increment with an explicit wrap, so non-power-of-two counts work.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first asserted request at or after ptr_i, wrapping mod N.
module rr_priority_picker #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  // Scan from the farthest offset down so the closest request to ptr_i wins last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = 32'(ptr_i) + 32'(k);
      if (cand >= 32'(N)) cand = cand - 32'(N);
      cand_idx = IW'(cand);
      if (req_i[cand_idx]) begin
        found_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers,
// with FIFO-full backpressure steered to the granted producer's ready.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  arb_state_t       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_id_q;
  logic [CNT_W-1:0] burst_cnt_q;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;

  rr_priority_picker #(.N(NUM_REQ)) u_picker (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  logic [DATA_WIDTH-1:0] data_slices [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slices
    assign data_slices[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  logic granted;
  logic g_valid;
  logic g_last;
  logic xfer;
  logic burst_done;
  logic release_grant;

  assign granted    = (state_q == ARB_GRANT);
  assign g_valid    = req_valid[grant_id_q];
  assign g_last     = req_last[grant_id_q];
  assign xfer       = granted & g_valid & ~fifo_full;
  assign burst_done = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
  // A stalled-by-full grant is held; only abandon, last, or a full burst release it.
  assign release_grant = granted & (~g_valid | (xfer & (g_last | burst_done)));

  always_comb begin
    req_ready = '0;
    if (granted) req_ready[grant_id_q] = ~fifo_full;
  end

  assign fifo_wr    = xfer;
  assign fifo_wdata = data_slices[grant_id_q];
  assign grant_id   = grant_id_q;
  assign busy       = granted;

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (pick_found) begin
            grant_id_q  <= pick_idx;
            burst_cnt_q <= '0;
            state_q     <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (xfer) burst_cnt_q <= burst_cnt_q + 1'b1;
          if (release_grant) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= IDX_W'(rr_next(32'(grant_id_q), NUM_REQ));
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: queue-driven producers, a transaction-level arbitration
// model compared every cycle, and directed scenarios with expected write sequences.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_last = '0;
  logic [NR-1:0]     req_ready;
  logic              fifo_full = 1'b0;
  logic              fifo_wr;
  logic [DW-1:0]     fifo_wdata;
  logic [1:0]        grant_id;
  logic              busy;

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int run_start = 0;
  int start_at [NR];
  int ff_from = 0;
  int ff_to   = 0;
  bit rand_full = 0;

  logic [DW-1:0] q_data [NR][$];
  bit            q_last [NR][$];

  int            wl_id   [$];
  logic [DW-1:0] wl_data [$];
  int            wl_cyc  [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: owner is the granted producer (-1 when idle), sent counts
  // words of the current burst, ptr is where the next round-robin scan starts.
  int m_owner = -1, m_gid = 0, m_ptr = 0, m_sent = 0;
  int n_owner = -1, n_gid = 0, n_ptr = 0, n_sent = 0;
  int mg, mi;
  logic [NR-1:0] e_ready;
  logic          e_wr, e_busy;
  logic [DW-1:0] e_wd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner <= -1; m_gid <= 0; m_ptr <= 0; m_sent <= 0;
    end else begin
      m_owner <= n_owner; m_gid <= n_gid; m_ptr <= n_ptr; m_sent <= n_sent;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      n_owner = -1; n_gid = 0; n_ptr = 0; n_sent = 0;
    end else begin
      n_owner = m_owner; n_gid = m_gid; n_ptr = m_ptr; n_sent = m_sent;
      e_ready = '0;
      e_wr    = 1'b0;
      e_busy  = (m_owner >= 0);
      if (m_owner < 0) begin
        for (int k = 0; k < NR; k++) begin
          mi = (m_ptr + k) % NR;
          if (req_valid[mi] && n_owner < 0) begin
            n_owner = mi; n_gid = mi; n_sent = 0;
          end
        end
      end else begin
        mg = m_owner;
        e_ready[mg] = !fifo_full;
        e_wr = req_valid[mg] && !fifo_full;
        if (!req_valid[mg]) begin
          n_owner = -1; n_ptr = (mg + 1) % NR;
        end else if (e_wr) begin
          n_sent = m_sent + 1;
          if (req_last[mg] || n_sent == MB) begin
            n_owner = -1; n_ptr = (mg + 1) % NR;
          end
        end
      end
      e_wd = req_data[m_gid*DW +: DW];
      total += 5;
      if (fifo_wr !== e_wr) begin bad++; $display("FAIL mon_fifo_wr cyc=%0d got=%b exp=%b", cyc, fifo_wr, e_wr); end
      if (req_ready !== e_ready) begin bad++; $display("FAIL mon_req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, e_ready); end
      if (busy !== e_busy) begin bad++; $display("FAIL mon_busy cyc=%0d got=%b exp=%b", cyc, busy, e_busy); end
      if (grant_id !== 2'(m_gid)) begin bad++; $display("FAIL mon_grant_id cyc=%0d got=%0d exp=%0d", cyc, grant_id, m_gid); end
      if (fifo_wdata !== e_wd) begin bad++; $display("FAIL mon_fifo_wdata cyc=%0d got=%h exp=%h", cyc, fifo_wdata, e_wd); end
      if (fifo_wr === 1'b1) begin
        wl_id.push_back(int'(grant_id)); wl_data.push_back(fifo_wdata); wl_cyc.push_back(cyc);
      end
    end
  end

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (q_data[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive();
    bit v;
    for (int i = 0; i < NR; i++) begin
      v = (q_data[i].size() > 0) && ((cyc - run_start) >= start_at[i]);
      req_valid[i] = v;
      req_data[i*DW +: DW] = v ? q_data[i][0] : DW'($urandom);
      req_last[i] = v && q_last[i][0];
    end
    fifo_full = (((cyc - run_start) >= ff_from) && ((cyc - run_start) < ff_to))
                || (rand_full && ($urandom_range(0, 3) == 0));
  endtask

  task automatic run(input int budget);
    logic [NR-1:0] acc;
    int n;
    run_start = cyc;
    drive();
    n = 0;
    while (pending() && n < budget) begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NR; i++)
        if (acc[i]) begin void'(q_data[i].pop_front()); void'(q_last[i].pop_front()); end
      drive();
      n++;
    end
    total++;
    if (pending()) begin bad++; $display("FAIL run_timeout cycles=%0d limit=%0d", n, budget); end
    repeat (4) begin @(posedge clk); #1; drive(); end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < NR; i++) begin q_data[i].delete(); q_last[i].delete(); start_at[i] = 0; end
    ff_from = 0; ff_to = 0; rand_full = 0;
    req_valid = '0; req_last = '0; req_data = '0; fifo_full = 1'b0;
  endtask

  task automatic do_reset();
    clear_stim();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    wl_id.delete(); wl_data.delete(); wl_cyc.delete();
  endtask

  task automatic push_word(input int r, input logic [DW-1:0] d, input bit l);
    q_data[r].push_back(d); q_last[r].push_back(l);
  endtask

  task automatic test_reset();
    clear_stim();
    req_data = NR*DW'($urandom);
    repeat (2) @(posedge clk); #1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    if (fifo_wr !== 1'b0) begin bad++; $display("FAIL rst_fifo_wr got=%b exp=0", fifo_wr); end
    if (req_ready !== '0) begin bad++; $display("FAIL rst_req_ready got=%b exp=0", req_ready); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id got=%0d exp=0", grant_id); end
    if (fifo_wdata !== req_data[DW-1:0]) begin bad++; $display("FAIL rst_fifo_wdata got=%h exp=%h", fifo_wdata, req_data[DW-1:0]); end
    @(negedge clk); #1 reset = 1'b0;
    req_data = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || fifo_wr !== 1'b0) begin bad++; $display("FAIL idle_quiet cyc=%0d busy=%b fifo_wr=%b exp=0/0", cyc, busy, fifo_wr); end
    end
  endtask

  task automatic test_two_word();
    int eid[3] = '{1, 1, 3};
    int ed[3]  = '{8'h11, 8'h12, 8'h33};
    int eo[3]  = '{1, 2, 4};
    do_reset();
    push_word(1, 8'h11, 0); push_word(1, 8'h12, 1);
    push_word(3, 8'h33, 1);
    run(50);
    total++;
    if (wl_id.size() != 3) begin bad++; $display("FAIL two_word_count got=%0d exp=3", wl_id.size()); end
    else for (int k = 0; k < 3; k++) begin
      total++;
      if (wl_id[k] != eid[k] || wl_data[k] != DW'(ed[k]) || wl_cyc[k] - run_start != eo[k]) begin
        bad++; $display("FAIL two_word_%0d got id=%0d d=%h t=%0d exp id=%0d d=%h t=%0d", k,
                        wl_id[k], wl_data[k], wl_cyc[k] - run_start, eid[k], ed[k], eo[k]);
      end
    end
  endtask

  task automatic test_max_burst();
    int eo[6] = '{1, 2, 3, 4, 6, 7};
    do_reset();
    for (int k = 0; k < 6; k++) push_word(0, DW'(8'hA0 + k), 0);
    run(50);
    total++;
    if (wl_id.size() != 6) begin bad++; $display("FAIL max_burst_count got=%0d exp=6", wl_id.size()); end
    else for (int k = 0; k < 6; k++) begin
      total++;
      if (wl_id[k] != 0 || wl_data[k] != DW'(8'hA0 + k) || wl_cyc[k] - run_start != eo[k]) begin
        bad++; $display("FAIL max_burst_%0d got id=%0d d=%h t=%0d exp id=0 d=%h t=%0d", k,
                        wl_id[k], wl_data[k], wl_cyc[k] - run_start, 8'hA0 + k, eo[k]);
      end
    end
  endtask

  task automatic test_all_four();
    int eid[5] = '{0, 1, 2, 3, 0};
    int ed[5]  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    do_reset();
    push_word(0, 8'h40, 1); push_word(0, 8'h44, 1);
    push_word(1, 8'h41, 1); push_word(2, 8'h42, 1); push_word(3, 8'h43, 1);
    run(50);
    total++;
    if (wl_id.size() != 5) begin bad++; $display("FAIL all_four_count got=%0d exp=5", wl_id.size()); end
    else for (int k = 0; k < 5; k++) begin
      total++;
      if (wl_id[k] != eid[k] || wl_data[k] != DW'(ed[k]) || wl_cyc[k] - run_start != 1 + 2*k) begin
        bad++; $display("FAIL all_four_%0d got id=%0d d=%h t=%0d exp id=%0d d=%h t=%0d", k,
                        wl_id[k], wl_data[k], wl_cyc[k] - run_start, eid[k], ed[k], 1 + 2*k);
      end
    end
  endtask

  task automatic test_full_stall();
    int eo[4] = '{1, 2, 6, 7};
    do_reset();
    for (int k = 0; k < 4; k++) push_word(2, DW'(8'h20 + k), k == 3);
    ff_from = 3; ff_to = 6;
    run(50);
    total++;
    if (wl_id.size() != 4) begin bad++; $display("FAIL full_stall_count got=%0d exp=4", wl_id.size()); end
    else for (int k = 0; k < 4; k++) begin
      total++;
      if (wl_id[k] != 2 || wl_data[k] != DW'(8'h20 + k) || wl_cyc[k] - run_start != eo[k]) begin
        bad++; $display("FAIL full_stall_%0d got id=%0d d=%h t=%0d exp id=2 d=%h t=%0d", k,
                        wl_id[k], wl_data[k], wl_cyc[k] - run_start, 8'h20 + k, eo[k]);
      end
    end
  endtask

  task automatic test_abandon();
    int eid[3] = '{1, 2, 0};
    int ed[3]  = '{8'h51, 8'h52, 8'h50};
    int eo[3]  = '{1, 4, 6};
    do_reset();
    push_word(1, 8'h51, 0);
    push_word(0, 8'h50, 1); push_word(2, 8'h52, 1);
    start_at[0] = 2; start_at[2] = 2;
    run(50);
    total++;
    if (wl_id.size() != 3) begin bad++; $display("FAIL abandon_count got=%0d exp=3", wl_id.size()); end
    else for (int k = 0; k < 3; k++) begin
      total++;
      if (wl_id[k] != eid[k] || wl_data[k] != DW'(ed[k]) || wl_cyc[k] - run_start != eo[k]) begin
        bad++; $display("FAIL abandon_%0d got id=%0d d=%h t=%0d exp id=%0d d=%h t=%0d", k,
                        wl_id[k], wl_data[k], wl_cyc[k] - run_start, eid[k], ed[k], eo[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data[3*DW +: DW] = 8'h77;
    req_data[DW-1:0] = 8'h5A;
    req_valid = 4'b1000;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total += 2;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_pre_busy got=%b exp=1", busy); end
    if (grant_id !== 2'd3) begin bad++; $display("FAIL mid_pre_grant got=%0d exp=3", grant_id); end
    #2 reset = 1'b1;
    #1;
    total += 5;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    if (fifo_wr !== 1'b0) begin bad++; $display("FAIL mid_fifo_wr got=%b exp=0", fifo_wr); end
    if (req_ready !== '0) begin bad++; $display("FAIL mid_req_ready got=%b exp=0", req_ready); end
    if (grant_id !== 2'd0) begin bad++; $display("FAIL mid_grant_id got=%0d exp=0", grant_id); end
    if (fifo_wdata !== 8'h5A) begin bad++; $display("FAIL mid_fifo_wdata got=%h exp=5a", fifo_wdata); end
    clear_stim();
    @(negedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    logic [DW-1:0] exp_q [NR][$];
    logic [DW-1:0] got_q [$];
    int nb, len;
    do_reset();
    for (int i = 0; i < NR; i++) begin
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        len = $urandom_range(1, 6);
        for (int w = 0; w < len; w++) push_word(i, DW'($urandom), (w == len - 1) && ($urandom_range(0, 3) != 0));
      end
      exp_q[i] = q_data[i];
      start_at[i] = $urandom_range(0, 10);
    end
    rand_full = 1;
    run(3000);
    rand_full = 0;
    fifo_full = 1'b0;
    for (int i = 0; i < NR; i++) begin
      got_q.delete();
      for (int k = 0; k < wl_id.size(); k++) if (wl_id[k] == i) got_q.push_back(wl_data[k]);
      total++;
      if (got_q.size() != exp_q[i].size()) begin
        bad++; $display("FAIL rand_count_%0d got=%0d exp=%0d", i, got_q.size(), exp_q[i].size());
      end else for (int k = 0; k < got_q.size(); k++) begin
        total++;
        if (got_q[k] !== exp_q[i][k]) begin bad++; $display("FAIL rand_data_%0d_%0d got=%h exp=%h", i, k, got_q[k], exp_q[i][k]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_two_word();
    test_max_burst();
    test_all_four();
    test_full_stall();
    test_abandon();
    test_reset_mid();
    for (int r = 0; r < 5; r++) test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
